// File: rtl/branch_redirect_pkg.sv
// branch_redirect_pkg
//  Shared types and helpers for the branch redirect block: tag and tag-mask
//  types, FSM state encoding, PC increment and small combinational helpers.
//  Optional feature macro used elsewhere in this slice: BRANCH_STATS_EN.
package branch_redirect_pkg;

    localparam int BR_TAG_NUM = 4;
    localparam int BR_TAG_W   = 2;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef logic [BR_TAG_W-1:0]   btag_t;
    typedef logic [BR_TAG_NUM-1:0] bmask_t;

    typedef enum logic [0:0] {
        BR_RUN   = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_e;

    // One-hot mask for a single tag.
    function automatic bmask_t tag_onehot(input btag_t t);
        bmask_t m;
        m    = '0;
        m[t] = 1'b1;
        return m;
    endfunction

    // Lowest-index clear bit of the busy vector; 0 when nothing is free
    // (callers qualify with a free-available flag).
    function automatic btag_t lowest_free(input bmask_t busy);
        btag_t t;
        t = '0;
        for (int i = BR_TAG_NUM - 1; i >= 0; i--) begin
            t = busy[i] ? t : btag_t'(i);
        end
        return t;
    endfunction

    // Saturating 32-bit increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/branch_redirect_if.sv
// branch_redirect_if
//  Bundles the fetch, tag-allocation, branch-result and kill signals of the
//  branch redirect block.
//  slave  : the redirect block (drives pcOut/pcValid, alloc*, kill*, busyMask)
//  master : the surrounding pipeline (drives fetchStall, allocReq, branch result)
//  With BRANCH_STATS_EN defined, statResolved/statMispred are added.
interface branch_redirect_if;
    import branch_redirect_pkg::*;

    logic [31:0] pcOut;
    logic        pcValid;
    logic        fetchStall;
    logic        allocReq;
    logic        allocGrant;
    btag_t       allocTag;
    bmask_t      allocDepMask;
    logic        BranchResultEn;
    logic [31:0] BranchAddr;
    btag_t       bFreeNum;
    logic        misTaken;
    logic        killEn;
    bmask_t      killMask;
    bmask_t      busyMask;
`ifdef BRANCH_STATS_EN
    logic [31:0] statResolved;
    logic [31:0] statMispred;
`endif

    modport slave (
        input  fetchStall, allocReq, BranchResultEn, BranchAddr, bFreeNum, misTaken,
        output pcOut, pcValid, allocGrant, allocTag, allocDepMask, killEn, killMask, busyMask
`ifdef BRANCH_STATS_EN
        , output statResolved, statMispred
`endif
    );

    modport master (
        output fetchStall, allocReq, BranchResultEn, BranchAddr, bFreeNum, misTaken,
        input  pcOut, pcValid, allocGrant, allocTag, allocDepMask, killEn, killMask, busyMask
`ifdef BRANCH_STATS_EN
        , input statResolved, statMispred
`endif
    );

endinterface

// File: rtl/branch_redirect_tag_pool.sv
// branch_redirect_tag_pool
//  Branch tag pool: busy vector, per-tag dependency masks (tags each branch is
//  younger than), lowest-free tag pick and kill-set computation.
//  Ports:
//   clk, rst      clock, async active-low reset
//   alloc_en      qualified grant from the top level; allocates alloc_tag
//   res_en/res_tag/res_taken  branch resolution from the branch unit
//   busy          registered busy vector
//   free_avail    at least one tag is free
//   alloc_tag     lowest free tag; alloc_dep its dependency mask
//   res_valid     resolution refers to a live tag
//   kill_set      resolved tag plus every live tag younger than it
module branch_redirect_tag_pool
    import branch_redirect_pkg::*;
#(
    parameter int TAG_NUM = BR_TAG_NUM
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   alloc_en,
    input  logic   res_en,
    input  btag_t  res_tag,
    input  logic   res_taken,
    output bmask_t busy,
    output logic   free_avail,
    output btag_t  alloc_tag,
    output bmask_t alloc_dep,
    output logic   res_valid,
    output bmask_t kill_set
);

    bmask_t busy_r;
    bmask_t dep_r      [TAG_NUM];
    bmask_t dep_nxt_s  [TAG_NUM];
    bmask_t busy_nxt_s;
    bmask_t res_onehot_s;
    bmask_t freeing_s;
    bmask_t clear_s;
    bmask_t alloc_set_s;
    bmask_t kill_set_s;
    logic   res_valid_s;

    // A resolution for a tag that is no longer busy (already killed) is dropped.
    assign res_valid_s  = res_en & busy_r[res_tag];
    assign res_onehot_s = tag_onehot(res_tag);
    assign freeing_s    = res_valid_s ? res_onehot_s : '0;
    assign alloc_set_s  = alloc_en ? tag_onehot(alloc_tag) : '0;

    // Kill set: the resolved tag plus every live tag that depends on it.
    always_comb begin
        kill_set_s = res_onehot_s;
        for (int i = 0; i < TAG_NUM; i++) begin
            kill_set_s[i] = kill_set_s[i] | (busy_r[i] & dep_r[i][res_tag]);
        end
    end

    // Tags to release this cycle: one tag on a correct prediction, the kill set on a mispredict.
    always_comb begin
        if (res_valid_s && res_taken) begin
            clear_s = kill_set_s;
        end else begin
            clear_s = freeing_s;
        end
    end

    // Next busy vector and dependency masks; a new grant writes its own mask fresh.
    always_comb begin
        busy_nxt_s = (busy_r & ~clear_s) | alloc_set_s;
        for (int i = 0; i < TAG_NUM; i++) begin
            dep_nxt_s[i] = alloc_set_s[i] ? alloc_dep : (dep_r[i] & ~clear_s);
        end
    end

    // Busy vector and dependency mask registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
            for (int i = 0; i < TAG_NUM; i++) begin
                dep_r[i] <= '0;
            end
        end else begin
            busy_r <= busy_nxt_s;
            for (int i = 0; i < TAG_NUM; i++) begin
                dep_r[i] <= dep_nxt_s[i];
            end
        end
    end

    // The picked tag comes from the registered vector, so a tag freed this cycle waits one cycle.
    assign alloc_tag  = lowest_free(busy_r);
    assign alloc_dep  = busy_r & ~freeing_s;
    assign free_avail = |(~busy_r);
    assign busy       = busy_r;
    assign res_valid  = res_valid_s;
    assign kill_set   = kill_set_s;

endmodule

// File: rtl/branch_redirect.sv
// branch_redirect
//  Consumer end of the branch-unit result bus. Owns the fetch PC and the
//  branch-tag pool. Fetch predicts not-taken, so a taken resolution of a live
//  tag is a mispredict: the PC is redirected and a registered one-cycle kill
//  mask is issued for the branch and all younger tagged work.
//  Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   branch_redirect_if.slave: fetch PC, tag allocation, branch result, kill
//  Parameters: RESET_PC (PC after reset), TAG_NUM (fixed at 4).
//  Optional: BRANCH_STATS_EN adds saturating resolution/mispredict counters.
module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          TAG_NUM  = BR_TAG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    branch_redirect_if.slave  bus
);

    br_state_e   state_r;
    logic [31:0] pc_r;
    logic        pc_valid_r;
    logic        kill_en_r;
    bmask_t      kill_mask_r;

    bmask_t      busy_s;
    logic        free_avail_s;
    btag_t       alloc_tag_s;
    bmask_t      alloc_dep_s;
    logic        res_valid_s;
    bmask_t      kill_set_s;
    logic        mispredict_s;
    logic        grant_s;

    assign mispredict_s = res_valid_s & bus.misTaken;

    // No grants during a flush or in the same cycle as a mispredict; decode retries.
    assign grant_s = bus.allocReq & (state_r == BR_RUN) & free_avail_s & ~mispredict_s;

    branch_redirect_tag_pool #(
        .TAG_NUM (TAG_NUM)
    ) u_tag_pool (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (grant_s),
        .res_en     (bus.BranchResultEn),
        .res_tag    (bus.bFreeNum),
        .res_taken  (bus.misTaken),
        .busy       (busy_s),
        .free_avail (free_avail_s),
        .alloc_tag  (alloc_tag_s),
        .alloc_dep  (alloc_dep_s),
        .res_valid  (res_valid_s),
        .kill_set   (kill_set_s)
    );

    // Redirect FSM with PC, fetch-valid and kill registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= BR_RUN;
            pc_r        <= RESET_PC;
            pc_valid_r  <= 1'b1;
            kill_en_r   <= 1'b0;
            kill_mask_r <= '0;
        end else begin
            case (state_r)
                BR_RUN: begin
                    if (mispredict_s) begin
                        state_r <= BR_FLUSH;
                        pc_r    <= bus.BranchAddr;
                    end else if (pc_valid_r && !bus.fetchStall) begin
                        state_r <= BR_RUN;
                        pc_r    <= pc_r + PC_STEP;
                    end else begin
                        state_r <= BR_RUN;
                        pc_r    <= pc_r;
                    end
                end
                BR_FLUSH: begin
                    // An older tag may still mispredict while flushing: flush again.
                    if (mispredict_s) begin
                        state_r <= BR_FLUSH;
                        pc_r    <= bus.BranchAddr;
                    end else begin
                        state_r <= BR_RUN;
                        pc_r    <= pc_r;
                    end
                end
                default: begin
                    state_r <= BR_RUN;
                    pc_r    <= pc_r;
                end
            endcase
            pc_valid_r  <= ~mispredict_s;
            kill_en_r   <= mispredict_s;
            kill_mask_r <= mispredict_s ? kill_set_s : '0;
        end
    end

    assign bus.pcOut        = pc_r;
    assign bus.pcValid      = pc_valid_r;
    assign bus.allocGrant   = grant_s;
    assign bus.allocTag     = alloc_tag_s;
    assign bus.allocDepMask = alloc_dep_s;
    assign bus.killEn       = kill_en_r;
    assign bus.killMask     = kill_mask_r;
    assign bus.busyMask     = busy_s;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved_r;
    logic [31:0] stat_mispred_r;

    // Saturating counters of live resolutions and mispredicts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved_r <= 32'd0;
            stat_mispred_r  <= 32'd0;
        end else begin
            stat_resolved_r <= res_valid_s  ? sat_inc(stat_resolved_r) : stat_resolved_r;
            stat_mispred_r  <= mispredict_s ? sat_inc(stat_mispred_r)  : stat_mispred_r;
        end
    end

    assign bus.statResolved = stat_resolved_r;
    assign bus.statMispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect
//  Directed bench for branch_redirect. Stimulus pushes expected grants,
//  kills and fetch addresses into queues; a negedge monitor pops and
//  compares whenever the DUT presents one. Negative cases are checked inline.
module tb_branch_redirect;

    typedef struct packed {
        logic [1:0] tag;
        logic [3:0] dep;
    } alloc_exp_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] pc;
    } kill_exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alloc_exp_t  alloc_q [$];
    kill_exp_t   kill_q  [$];
    logic [31:0] pc_q    [$];
    alloc_exp_t  mon_a;
    kill_exp_t   mon_k;
    logic [31:0] mon_pc;
    logic [3:0]  dep_tbl [4];

    branch_redirect_if bus_if ();

    branch_redirect #(
        .RESET_PC (32'h0),
        .TAG_NUM  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic areq, input logic ren, input logic [1:0] tag,
                         input logic taken, input logic [31:0] addr, input logic stall);
        bus_if.allocReq       = areq;
        bus_if.BranchResultEn = ren;
        bus_if.bFreeNum       = tag;
        bus_if.misTaken       = taken;
        bus_if.BranchAddr     = addr;
        bus_if.fetchStall     = stall;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented grant, kill and fetch against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.allocGrant) begin
                if (alloc_q.size() == 0) begin
                    check("alloc_unexpected", 32'(bus_if.allocGrant), 32'd0);
                end else begin
                    mon_a = alloc_q.pop_front();
                    check("alloc_tag", 32'(bus_if.allocTag), 32'(mon_a.tag));
                    check("alloc_dep", 32'(bus_if.allocDepMask), 32'(mon_a.dep));
                end
            end
            if (bus_if.killEn) begin
                if (kill_q.size() == 0) begin
                    check("kill_unexpected", 32'(bus_if.killEn), 32'd0);
                end else begin
                    mon_k = kill_q.pop_front();
                    check("kill_mask", 32'(bus_if.killMask), 32'(mon_k.mask));
                    check("kill_pc", bus_if.pcOut, mon_k.pc);
                    check("kill_pcvalid", 32'(bus_if.pcValid), 32'd0);
                end
            end
            if (bus_if.pcValid && !bus_if.fetchStall) begin
                if (pc_q.size() == 0) begin
                    check("fetch_unexpected", 32'(bus_if.pcValid), 32'd0);
                end else begin
                    mon_pc = pc_q.pop_front();
                    check("fetch_pc", bus_if.pcOut, mon_pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        dep_tbl[0] = 4'b0000;
        dep_tbl[1] = 4'b0001;
        dep_tbl[2] = 4'b0011;
        dep_tbl[3] = 4'b0111;
        rst = 1'b0;
        idle();
        #12 rst = 1'b1;
        tick();

        // Reset state
        check("rst_pc",       bus_if.pcOut,            32'h0);
        check("rst_pcvalid",  32'(bus_if.pcValid),     32'd1);
        check("rst_killen",   32'(bus_if.killEn),      32'd0);
        check("rst_killmask", 32'(bus_if.killMask),    32'd0);
        check("rst_busy",     32'(bus_if.busyMask),    32'd0);

        // Sequential fetch 0,4,8,12
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
            pc_q.push_back(32'(i * 4));
            tick();
        end
        idle();
        check("pc_after_fetch", bus_if.pcOut, 32'h10);

        // Four grants with growing dependency masks, fifth refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
            alloc_q.push_back('{tag: 2'(i), dep: dep_tbl[i]});
            tick();
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("alloc_full_refused", 32'(bus_if.allocGrant), 32'd0);
        tick();
        idle();
        check("busy_full", 32'(bus_if.busyMask), 32'hF);

        // Mispredict tag1 -> kill 1110, redirect to 0x100
        drive(1'b0, 1'b1, 2'd1, 1'b1, 32'h100, 1'b1);
        kill_q.push_back('{mask: 4'b1110, pc: 32'h100});
        tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("flush_alloc_refused", 32'(bus_if.allocGrant), 32'd0);
        check("flush_busy",          32'(bus_if.busyMask),   32'b0001);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        pc_q.push_back(32'h100);
        check("run_pcvalid", 32'(bus_if.pcValid), 32'd1);
        check("run_killen",  32'(bus_if.killEn),  32'd0);
        tick();
        idle();

        // Refill tags 1..3, then free tag2 with a same-cycle request
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
            alloc_q.push_back('{tag: 2'(i), dep: dep_tbl[i]});
            tick();
        end
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("freed_tag_not_reused", 32'(bus_if.allocGrant), 32'd0);
        tick();
        // Grant tag2 while tag3 resolves not-taken in the same cycle
        drive(1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 1'b1);
        alloc_q.push_back('{tag: 2'd2, dep: 4'b0011});
        tick();
        idle();
        check("busy_after_swap", 32'(bus_if.busyMask), 32'b0111);

        // Mispredict tag0 -> kill 0111; late resolution of killed tag1 ignored
        drive(1'b0, 1'b1, 2'd0, 1'b1, 32'h200, 1'b1);
        kill_q.push_back('{mask: 4'b0111, pc: 32'h200});
        tick();
        drive(1'b0, 1'b1, 2'd1, 1'b1, 32'h240, 1'b1);
        @(negedge clk);
        check("flush_all_killed", 32'(bus_if.busyMask), 32'd0);
        tick();
        idle();
        check("no_second_kill", 32'(bus_if.killEn),  32'd0);
        check("redirect_pc",    bus_if.pcOut,        32'h200);
        check("pcvalid_back",   32'(bus_if.pcValid), 32'd1);

        // Back-to-back kills: tag1 mispredicts, then older tag0 during the flush
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
            alloc_q.push_back('{tag: 2'(i), dep: dep_tbl[i]});
            tick();
        end
        drive(1'b0, 1'b1, 2'd1, 1'b1, 32'h300, 1'b1);
        kill_q.push_back('{mask: 4'b0110, pc: 32'h300});
        tick();
        drive(1'b0, 1'b1, 2'd0, 1'b1, 32'h400, 1'b1);
        kill_q.push_back('{mask: 4'b0001, pc: 32'h400});
        tick();
        idle();
        tick();
        check("b2b_end_killen", 32'(bus_if.killEn),   32'd0);
        check("b2b_end_pc",     bus_if.pcOut,         32'h400);
        check("b2b_end_busy",   32'(bus_if.busyMask), 32'd0);
`ifdef BRANCH_STATS_EN
        check("stat_resolved", bus_if.statResolved, 32'd6);
        check("stat_mispred",  bus_if.statMispred,  32'd4);
`endif

        // Reset asserted in the middle of a flush
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        alloc_q.push_back('{tag: 2'd0, dep: 4'b0000});
        tick();
        drive(1'b0, 1'b1, 2'd0, 1'b1, 32'h500, 1'b1);
        kill_q.push_back('{mask: 4'b0001, pc: 32'h500});
        tick();
        idle();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_killen",   32'(bus_if.killEn),   32'd0);
        check("midrst_killmask", 32'(bus_if.killMask), 32'd0);
        check("midrst_pcvalid",  32'(bus_if.pcValid),  32'd1);
        check("midrst_pc",       bus_if.pcOut,         32'h0);
        check("midrst_busy",     32'(bus_if.busyMask), 32'd0);
`ifdef BRANCH_STATS_EN
        check("midrst_stat_res", bus_if.statResolved, 32'd0);
        check("midrst_stat_mis", bus_if.statMispred,  32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        check("post_rst_killen", 32'(bus_if.killEn), 32'd0);
        check("post_rst_pc",     bus_if.pcOut,       32'h0);

        check("alloc_q_drained", 32'(alloc_q.size()), 32'd0);
        check("kill_q_drained",  32'(kill_q.size()),  32'd0);
        check("pc_q_drained",    32'(pc_q.size()),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
